// File: rtl/result_streamer.sv
// Result streamer: captures a 4x4 result vector on done_i and streams the
// leading N x N sub-matrix row-major over a valid/ready handshake.
// Optional build macro: RESULT_STREAMER_PARITY_EN adds even parity on data_o.
//
// state  | meaning
// IDLE   | no frame pending; outputs hold last element, last_o low
// STREAM | buffer holds a frame; valid_o high until the last_o transfer
module result_streamer #(
  parameter int DATA_WIDTH  = 32,
  parameter int MATRIX_SIZE = 16,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              done_i,
  input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] res_i,
  input  logic [2:0]                        dim_i,
  output logic [DATA_WIDTH-1:0]             data_o,
  output logic [ADDR_WIDTH-1:0]             addr_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic                              last_o,
  output logic                              busy_o,
  output logic                              drop_o,
  output logic                              parity_o
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [0:0]            state_q;
  logic [DATA_WIDTH-1:0] buf_q [MATRIX_SIZE];
  logic [2:0]            n_q;
  logic [1:0]            row_q;
  logic [1:0]            col_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  last_q;
  logic                  drop_q;

  logic       xfer;
  logic       capture;
  logic       advance;
  logic [2:0] n_eff;
  logic [2:0] n_max;
  logic [1:0] nxt_row;
  logic [1:0] nxt_col;
  logic [3:0] nxt_idx;
  logic       nxt_last;

  assign busy_o  = (state_q == ST_STREAM);
  assign valid_o = busy_o;
  assign data_o  = data_q;
  assign addr_o  = addr_q;
  assign last_o  = last_q;
  assign drop_o  = drop_q;

  assign xfer    = valid_o & ready_i;
  // A done_i on the final handshake starts the next frame back to back.
  assign capture = done_i & ((state_q == ST_IDLE) | (xfer & last_q));
  assign advance = xfer & ~last_q;

  always_comb begin
    n_eff = dim_i;
    if ((dim_i == 3'd0) || (dim_i > 3'd4)) begin
      n_eff = 3'd4;
    end
  end

  assign n_max = n_q - 3'd1;

  always_comb begin
    nxt_row = row_q;
    nxt_col = col_q + 2'd1;
    if ({1'b0, col_q} == n_max) begin
      nxt_row = row_q + 2'd1;
      nxt_col = 2'd0;
    end
  end

  assign nxt_idx  = {nxt_row, nxt_col};
  assign nxt_last = ({1'b0, nxt_row} == n_max) && ({1'b0, nxt_col} == n_max);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < MATRIX_SIZE; k++) begin
        buf_q[k] <= '0;
      end
    end else if (capture) begin
      for (int k = 0; k < MATRIX_SIZE; k++) begin
        buf_q[k] <= res_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      n_q     <= 3'd4;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      data_q  <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= done_i & (state_q == ST_STREAM) & ~capture;
      if (capture) begin
        state_q <= ST_STREAM;
        n_q     <= n_eff;
        row_q   <= 2'd0;
        col_q   <= 2'd0;
        data_q  <= res_i[DATA_WIDTH-1:0];
        addr_q  <= '0;
        last_q  <= (n_eff == 3'd1);
      end else if (advance) begin
        row_q   <= nxt_row;
        col_q   <= nxt_col;
        data_q  <= buf_q[nxt_idx];
        addr_q  <= ADDR_WIDTH'(nxt_idx);
        last_q  <= nxt_last;
      end else if (xfer) begin
        state_q <= ST_IDLE;
        last_q  <= 1'b0;
      end
    end
  end

`ifdef RESULT_STREAMER_PARITY_EN
  assign parity_o = valid_o & (^data_q);
`else
  assign parity_o = 1'b0;
`endif

endmodule
